// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port between the M-stage access unit and memory.
interface mem_access_unit_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage load/store controller: drives a multi-cycle req/ack memory
// port, steers store lanes, extracts load bytes and stalls the pipe.
module mem_access_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               MemWriteM,
    input  logic               MemReadM,
    input  logic               StSrcM,
    input  logic               LdSrcM,
    input  logic [WIDTH-1:0]   ALUResultM,
    input  logic [WIDTH-1:0]   WriteDataM,
    output logic [WIDTH-1:0]   ReadDataM,
    output logic               StallM,
    mem_access_unit_if.master  mem
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_req;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_be;
    logic             r_ld_byte;
    logic [1:0]       r_lane;
    logic [WIDTH-1:0] r_rdata;

    logic             w_op;
    logic [7:0]       w_lane_byte;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;

    assign w_op = MemWriteM | MemReadM;

    // Byte stores replicate the byte on every lane; be picks the target.
    assign w_be    = (MemWriteM && StSrcM) ? (4'b0001 << ALUResultM[1:0])
                                           : 4'b1111;
    assign w_wdata = (MemWriteM && StSrcM) ? {4{WriteDataM[7:0]}}
                                           : WriteDataM;

    assign w_lane_byte = mem.mem_rdata[{r_lane, 3'b000} +: 8];

    // Releasing the stall in DONE lets the pipe advance exactly once.
    assign StallM = w_op & (r_state != S_DONE) & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= 4'b0000;
            r_ld_byte <= 1'b0;
            r_lane    <= 2'b00;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_req     <= 1'b1;
                        r_we      <= MemWriteM;
                        r_addr    <= {ALUResultM[WIDTH-1:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_ld_byte <= LdSrcM;
                        r_lane    <= ALUResultM[1:0];
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                        if (!r_we) begin
                            r_rdata <= r_ld_byte
                                     ? {{(WIDTH-8){1'b0}}, w_lane_byte}
                                     : mem.mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;
    assign ReadDataM     = r_rdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, stalls, reset.
module tb_mem_access_unit;
    logic        clk;
    logic        rst_n;
    logic        MemWriteM;
    logic        MemReadM;
    logic        StSrcM;
    logic        LdSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;

    int errors = 0;
    int checks = 0;
    int req_eps = 0;
    logic prev_req = 1'b0;

    mem_access_unit_if #(.WIDTH(32)) mif ();

    mem_access_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .StSrcM     (StSrcM),
        .LdSrcM     (LdSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .mem        (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mif.mem_req && !prev_req) req_eps++;
        prev_req = mif.mem_req;
    end

    // Captured observations of one access
    logic [31:0] o_addr, o_wdata, o_rd;
    logic [3:0]  o_be;
    logic        o_we, o_dstall, o_dreq;
    int          o_stalls;
    bit          o_stable;

    task automatic run_op(input logic we, input logic rd,
                          input logic st, input logic ld,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdv, input int k);
        @(posedge clk); #1;
        MemWriteM = we; MemReadM = rd; StSrcM = st; LdSrcM = ld;
        ALUResultM = a; WriteDataM = wd;
        o_stalls = 0;
        o_stable = 1'b1;
        #1;
        if (StallM) o_stalls++;
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                o_addr = mif.mem_addr; o_wdata = mif.mem_wdata;
                o_be = mif.mem_be; o_we = mif.mem_we;
            end else if (o_addr !== mif.mem_addr ||
                         o_wdata !== mif.mem_wdata ||
                         o_be !== mif.mem_be || o_we !== mif.mem_we) begin
                o_stable = 1'b0;
            end
            if (mif.mem_req !== 1'b1) o_stable = 1'b0;
            if (StallM) o_stalls++;
            mif.mem_rdata = rdv;
            if (c == k) mif.mem_ack = 1'b1;
        end
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 32'h0;
        o_dstall = StallM;
        o_dreq = mif.mem_req;
        o_rd = ReadDataM;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        MemWriteM = 0; MemReadM = 0; StSrcM = 0; LdSrcM = 0;
        ALUResultM = 0; WriteDataM = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MemReadM = 1'b1;
        #2;
        checks++;
        if (StallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", StallM);
        end
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be} !== 6'b0 ||
            mif.mem_addr !== 32'h0 || mif.mem_wdata !== 32'h0 ||
            ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL reset_outs req=%b we=%b be=%h addr=%h wd=%h rd=%h exp all 0",
                     mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr,
                     mif.mem_wdata, ReadDataM);
        end
        MemReadM = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sw();
        run_op(1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b1 ||
            o_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_bus addr=%h be=%b we=%b wd=%h exp 100 1111 1 deadbeef",
                     o_addr, o_be, o_we, o_wdata);
        end
        checks++;
        if (o_stalls != 2 || o_dstall !== 1'b0) begin
            errors++;
            $display("FAIL sw_stall cycles=%0d done=%b exp 2 0", o_stalls, o_dstall);
        end
        checks++;
        if (o_rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_rdata got=%h exp=0", o_rd);
        end
        go_idle();
    endtask

    task automatic test_sb();
        run_op(1, 0, 1, 0, 32'h103, 32'h000000A5, 32'h0, 1);
        checks++;
        if (o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 ||
            o_addr !== 32'h100 || o_we !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus be=%b wd=%h addr=%h we=%b exp 1000 a5a5a5a5 100 1",
                     o_be, o_wdata, o_addr, o_we);
        end
        go_idle();
    endtask

    task automatic test_lbu_delayed();
        run_op(0, 1, 0, 1, 32'h102, 32'h0, 32'h11223344, 4);
        checks++;
        if (!o_stable || o_addr !== 32'h100 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL lbu_hold stable=%b addr=%h we=%b exp 1 100 0",
                     o_stable, o_addr, o_we);
        end
        checks++;
        if (o_rd !== 32'h00000022) begin
            errors++;
            $display("FAIL lbu_data got=%h exp=00000022", o_rd);
        end
        checks++;
        if (o_stalls != 5 || o_dstall !== 1'b0 || o_dreq !== 1'b0) begin
            errors++;
            $display("FAIL lbu_stall cycles=%0d done=%b req=%b exp 5 0 0",
                     o_stalls, o_dstall, o_dreq);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        int eps0;
        eps0 = req_eps;
        run_op(0, 1, 0, 0, 32'h200, 32'h0, 32'hCAFEF00D, 1);
        checks++;
        if (o_rd !== 32'hCAFEF00D || o_addr !== 32'h200) begin
            errors++;
            $display("FAIL b2b_first rd=%h addr=%h exp cafef00d 200", o_rd, o_addr);
        end
        run_op(0, 1, 0, 0, 32'h204, 32'h0, 32'h0BADC0DE, 2);
        checks++;
        if (o_rd !== 32'h0BADC0DE || o_addr !== 32'h204) begin
            errors++;
            $display("FAIL b2b_second rd=%h addr=%h exp 0badc0de 204", o_rd, o_addr);
        end
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_eps - eps0 != 2) begin
            errors++;
            $display("FAIL b2b_episodes got=%0d exp=2", req_eps - eps0);
        end
    endtask

    task automatic test_both_high();
        run_op(1, 1, 0, 0, 32'h306, 32'h12345678, 32'hFFFFFFFF, 1);
        checks++;
        if (o_we !== 1'b1 || o_be !== 4'b1111 || o_addr !== 32'h304) begin
            errors++;
            $display("FAIL both_store we=%b be=%b addr=%h exp 1 1111 304",
                     o_we, o_be, o_addr);
        end
        checks++;
        if (o_rd !== 32'h0BADC0DE) begin
            errors++;
            $display("FAIL both_rdata got=%h exp=0badc0de", o_rd);
        end
        go_idle();
    endtask

    task automatic test_non_mem();
        bit bad;
        bad = 1'b0;
        ALUResultM = 32'h400;
        WriteDataM = 32'h55;
        mif.mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (StallM !== 1'b0 || mif.mem_req !== 1'b0) bad = 1'b1;
        end
        mif.mem_ack = 1'b0;
        checks++;
        if (bad || ReadDataM !== 32'h0BADC0DE) begin
            errors++;
            $display("FAIL non_mem bad=%b rd=%h exp 0 0badc0de", bad, ReadDataM);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        MemReadM = 1'b1; LdSrcM = 1'b0; ALUResultM = 32'h500;
        @(posedge clk); #1;
        checks++;
        if (mif.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre req=%b exp=1", mif.mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_drop req=%b stall=%b rd=%h exp 0 0 0",
                     mif.mem_req, StallM, ReadDataM);
        end
        MemReadM = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ReadDataM !== 32'h0 || mif.mem_req !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_spurious rd=%h req=%b stall=%b exp 0 0 0",
                     ReadDataM, mif.mem_req, StallM);
        end
    endtask

    initial begin
        MemWriteM = 0; MemReadM = 0; StSrcM = 0; LdSrcM = 0;
        ALUResultM = 0; WriteDataM = 0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 32'h0;
        test_reset();
        test_sw();
        test_sb();
        test_lbu_delayed();
        test_back_to_back();
        test_both_high();
        test_non_mem();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
